// File: rtl/reflex_controller.sv
// Reaction-trial sequencer: random pre-stimulus wait, BCD ms timing, best-record compare/commit.
// Latency: start -> busy next cycle; button -> DONE/led off/write_enable next cycle; outputs registered.
// Backpressure: none; start/button are single-cycle pulses, ignored in states that do not use them.
// Ports: ck/reset (async active-low) | start, button pulses | rec0..rec3 stored best (BCD, rec0 LSD)
//        cnt0..cnt3 trial time (BCD ms) | write_enable record commit pulse | led, busy | early, new_record flags
module reflex_controller #(
    parameter int TICK_DIV        = 100000,
    parameter int WAIT_MIN_MS     = 1000,
    parameter int WAIT_RANGE_BITS = 11
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       start,
    input  logic       button,
    input  logic [3:0] rec0,
    input  logic [3:0] rec1,
    input  logic [3:0] rec2,
    input  logic [3:0] rec3,
    output logic [3:0] cnt0,
    output logic [3:0] cnt1,
    output logic [3:0] cnt2,
    output logic [3:0] cnt3,
    output logic       write_enable,
    output logic       led,
    output logic       busy,
    output logic       early,
    output logic       new_record
);
    localparam int PW  = $clog2(TICK_DIV);
    localparam int WCW = $clog2(WAIT_MIN_MS + (1 << WAIT_RANGE_BITS));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MEASURE,
        S_DONE,
        S_FOUL
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      lfsr;
    logic [PW-1:0]    presc;
    logic [WCW-1:0]   wait_cnt;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_inc;
    logic             tick;
    logic             enter_wait;
    logic             enter_meas;
    logic             cnt_max;
    logic             beats_record;

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign cnt_max = (cnt_q == 16'h9999);
    // Valid BCD nibbles order the same way as the binary value, so a plain
    // unsigned compare is the MSD-first digit compare.
    assign beats_record = (cnt_q < {rec3, rec2, rec1, rec0});

    assign led  = (state == S_MEASURE);
    assign busy = (state == S_WAIT) || (state == S_MEASURE);
    assign {cnt3, cnt2, cnt1, cnt0} = cnt_q;

    // BCD +1 with ripple carry 9 -> 0 into the next digit.
    always_comb begin
        logic carry;
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (cnt_q[d*4 +: 4] == 4'd9) begin
                    cnt_inc[d*4 +: 4] = 4'd0;
                end else begin
                    cnt_inc[d*4 +: 4] = cnt_q[d*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_FOUL: begin
                if (start) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A button on the final tick still counts as a false start.
                if (button)                          state_nxt = S_FOUL;
                else if (tick && wait_cnt == WCW'(1)) state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (button)              state_nxt = S_DONE;
                else if (tick && cnt_max) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        enter_wait = (state != S_WAIT)    && (state_nxt == S_WAIT);
        enter_meas = (state != S_MEASURE) && (state_nxt == S_MEASURE);
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            lfsr         <= 16'hACE1;
            presc        <= '0;
            wait_cnt     <= '0;
            cnt_q        <= '0;
            early        <= 1'b0;
            new_record   <= 1'b0;
            write_enable <= 1'b0;
        end else begin
            // Nonzero seed with a maximal-length tap set keeps it off all-zero.
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            if (enter_wait || enter_meas || tick) presc <= '0;
            else                                  presc <= presc + PW'(1);

            write_enable <= 1'b0;

            if (enter_wait) begin
                wait_cnt   <= WCW'(WAIT_MIN_MS) + WCW'(lfsr[WAIT_RANGE_BITS-1:0]);
                cnt_q      <= '0;
                early      <= 1'b0;
                new_record <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (button)    early    <= 1'b1;
                        else if (tick) wait_cnt <= wait_cnt - WCW'(1);
                    end
                    S_MEASURE: begin
                        // Button wins over a coincident tick: the time is frozen as-is.
                        if (button) begin
                            if (beats_record) begin
                                write_enable <= 1'b1;
                                new_record   <= 1'b1;
                            end
                        end else if (tick && !cnt_max) begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reflex_controller.sv
module tb_reflex_controller;
    localparam int TD   = 4;
    localparam int WMIN = 2;
    localparam int WRB  = 2;

    logic       ck;
    logic       reset;
    logic       start;
    logic       button;
    logic [3:0] rec0, rec1, rec2, rec3;
    logic [3:0] cnt0, cnt1, cnt2, cnt3;
    logic       write_enable, led, busy, early, new_record;

    logic [15:0] rec_mem;
    logic        mem_load;
    logic [15:0] mem_val;
    logic [15:0] cntv;

    int          checks;
    int          errors;
    int          we_count;
    int          mrec;
    logic [15:0] mlfsr;

    reflex_controller #(
        .TICK_DIV(TD), .WAIT_MIN_MS(WMIN), .WAIT_RANGE_BITS(WRB)
    ) dut (
        .ck(ck), .reset(reset), .start(start), .button(button),
        .rec0(rec0), .rec1(rec1), .rec2(rec2), .rec3(rec3),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
        .write_enable(write_enable), .led(led), .busy(busy),
        .early(early), .new_record(new_record)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Record memory: commits the trial time on write_enable.
    always @(posedge ck) begin
        if (mem_load)          rec_mem <= mem_val;
        else if (write_enable) rec_mem <= {cnt3, cnt2, cnt1, cnt0};
    end
    assign {rec3, rec2, rec1, rec0} = rec_mem;
    assign cntv = {cnt3, cnt2, cnt1, cnt0};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge ck);
        if (reset) mlfsr = lfsr_next(mlfsr);
        #1;
        if (write_enable) we_count++;
    endtask

    // foul_off >= 0: button that many cycles after WAIT entry.
    // react < 0: never press (timeout); else press react cycles after led rises.
    task automatic trial(input int foul_off, input int react, input bit with_btn, input bit start_mid);
        int rnd, dly, t, k, we0;
        bit less;
        rnd = int'(mlfsr[WRB-1:0]);
        dly = (WMIN + rnd) * TD;
        start = 1'b1; button = with_btn; step(); start = 1'b0; button = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_led", 32'(led), 32'd0);
        chk("wait_flags_clear", 32'({early, new_record}), 32'd0);
        chk("wait_cnt_clear", 32'(cntv), 32'd0);
        we0 = we_count;
        if (foul_off >= 0) begin
            repeat (foul_off) step();
            button = 1'b1; step(); button = 1'b0;
            chk("foul_early", 32'(early), 32'd1);
            chk("foul_busy", 32'(busy), 32'd0);
            t = 0;
            repeat (dly + 4) begin step(); if (led) t++; end
            chk("foul_led_never", 32'(t), 32'd0);
            chk("foul_no_write", 32'(we_count - we0), 32'd0);
            chk("foul_cnt", 32'(cntv), 32'd0);
            chk("foul_early_held", 32'(early), 32'd1);
            return;
        end
        t = 0;
        while (!led && t < dly + 10) begin step(); t++; end
        chk("wait_len", 32'(t), 32'(dly));
        if (react < 0) begin
            t = 0;
            while (led && t < 10000 * TD + 10) begin step(); t++; end
            chk("timeout_len", 32'(t), 32'(10000 * TD));
            chk("timeout_cnt", 32'(cntv), 32'h9999);
            chk("timeout_no_write", 32'(we_count - we0), 32'd0);
            chk("timeout_busy", 32'(busy), 32'd0);
            return;
        end
        for (int i = 0; i < react; i++) begin
            if (start_mid && i == 2) start = 1'b1;
            step();
            start = 1'b0;
            if (start_mid && i == 2) chk("start_in_measure_ignored", 32'({led, busy}), 32'b11);
        end
        k = (react / TD > 9999) ? 9999 : react / TD;
        chk("react_cnt", 32'(cntv), 32'(to_bcd(k)));
        less = (k < mrec);
        button = 1'b1; step(); button = 1'b0;
        chk("done_led", 32'(led), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_we", 32'(write_enable), 32'(less));
        chk("done_new_record", 32'(new_record), 32'(less));
        chk("done_cnt", 32'(cntv), 32'(to_bcd(k)));
        step();
        chk("we_one_cycle", 32'(write_enable), 32'd0);
        chk("we_total", 32'(we_count - we0), 32'(less));
        if (less) mrec = k;
        chk("record_mem", 32'(rec_mem), 32'(to_bcd(mrec)));
        chk("new_record_held", 32'(new_record), 32'(less));
    endtask

    initial begin
        int t;
        checks = 0; errors = 0; we_count = 0;
        start = 1'b0; button = 1'b0;
        reset = 1'b0; mlfsr = 16'hACE1;
        mem_val = 16'h9999; mem_load = 1'b1; mrec = 9999;
        repeat (3) step();
        mem_load = 1'b0;
        chk("reset_outputs", 32'({cntv, write_enable, led, busy, early, new_record}), 32'd0);
        reset = 1'b1;

        // Idle with stray button pulses: nothing moves.
        for (int i = 0; i < 20; i++) begin
            button = i[0];
            step();
            chk("idle_outputs", 32'({cntv, write_enable, led, busy, early, new_record}), 32'd0);
        end
        button = 1'b0;

        trial(-1, 13, 1'b0, 1'b0);        // 3 ms, new record
        trial(-1, 12, 1'b0, 1'b0);        // 3 ms, equal -> no write
        trial(-1, 21, 1'b0, 1'b0);        // 5 ms, greater -> no write
        trial(3, 0, 1'b0, 1'b0);          // false start
        trial(-1, 4 * 8 - 1, 1'b1, 1'b1); // button on tick at 0007; start+button, mid-measure start

        // Randomized trials against the model.
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 3) == 0)
                trial(int'($urandom_range(0, WMIN * TD - 1)), 0, 1'($urandom_range(0, 1)), 1'b0);
            else
                trial(-1, int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset during MEASURE at 0002.
        start = 1'b1; step(); start = 1'b0;
        t = 0;
        while (!led && t < (WMIN + (1 << WRB)) * TD + 10) begin step(); t++; end
        chk("rst_led_rise", 32'(led), 32'd1);
        repeat (2 * TD) step();
        chk("rst_pre_cnt", 32'(cntv), 32'h0002);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({cntv, write_enable, led, busy, early, new_record}), 32'd0);
        mlfsr = 16'hACE1;
        step(); step();
        chk("rst_hold_outputs", 32'({cntv, write_enable, led, busy, early, new_record}), 32'd0);
        reset = 1'b1;
        step();
        chk("rst_record_kept", 32'(rec_mem), 32'(to_bcd(mrec)));
        chk("rst_idle", 32'({led, busy}), 32'd0);

        // Saturation at 9999 with record forced back to 9999.
        mem_val = 16'h9999; mem_load = 1'b1; step(); mem_load = 1'b0; mrec = 9999;
        trial(-1, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reflex_controller.md
# reflex_controller

Sequencing controller for the reflex-measurement datapath. It runs one reaction trial per `start` pulse:
- waits a pseudo-random delay, then lights the stimulus LED;
- counts elapsed milliseconds in 4-digit BCD;
- compares the result against the stored best record and pulses the record memory's write enable when the record is beaten.

It sits between the debounced user inputs and the record memory, and it drives the BCD time shown on the display.

## Interface
- `TICK_DIV`, 100000: `ck` cycles per 1 ms tick (≥2).
- `WAIT_MIN_MS`, 1000: fixed part of the pre-stimulus delay, in ms (≥1).
- `WAIT_RANGE_BITS`, 11: width of the random delay addend (adds 0..2^W−1 ms); ≤16.

Ports:
- `ck` in 1: clock. All logic is single clock domain, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle, already-debounced start pulse.
- `button` in 1: single-cycle, already-debounced reaction pulse.
- `rec0`..`rec3` in 4 each: stored best time (BCD), from the record memory; `rec0` is the least-significant digit.
- `cnt0`..`cnt3` out 4 each: current trial time (BCD ms); `cnt0` is the least-significant digit. Feeds the memory and the display.
- `write_enable` out 1: one-cycle pulse that commits `cnt*` as the new record.
- `led` out 1: stimulus light.
- `busy` out 1: high in WAIT or MEASURE.
- `early` out 1: false start flagged. Held until the next accepted `start`.
- `new_record` out 1: last trial beat the record. Held until the next accepted `start`.

## Operation
- States: IDLE, WAIT, MEASURE, DONE, FOUL.
- Reset values: state IDLE; all outputs 0 (`cnt*`=0000, `led`, `busy`, `early`, `new_record`, `write_enable` all 0); LFSR=16'hACE1; prescaler=0.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Shifts every `ck` cycle in every state, and never reaches all-zero.
- Prescaler: counts 0..TICK_DIV−1 and asserts `tick` for one cycle at TICK_DIV−1, then wraps. It is cleared on entry to WAIT and to MEASURE.
- IDLE, DONE, FOUL: `start` → WAIT. `button` is ignored.
- Entry to WAIT does the following:
  - loads the wait counter with WAIT_MIN_MS + LFSR[WAIT_RANGE_BITS−1:0], sampled in the `start` cycle;
  - clears `cnt*` to 0000;
  - clears `early` and `new_record`.
- WAIT: `start` is ignored.
  - `button` → FOUL, `early`=1.
  - Otherwise, each `tick` decrements the wait counter. A `tick` while the counter is 1 → MEASURE.
- MEASURE: `led`=1 and `start` is ignored.
  - Each `tick` increments `cnt*` as BCD, with carry 9→0 into the next digit.
  - `button` → DONE, and the compare is evaluated on the current `cnt*`.
  - `tick` while `cnt*`=9999 → DONE with `cnt*` held at 9999 (timeout, no increment past 9999, no write).
- Compare: a BCD magnitude compare, most-significant digit (`cnt3` vs `rec3`) first. The condition is strict less-than; an equal time does not write.
- If `cnt*` < `rec*` at the `button` cycle, then in the first DONE cycle `write_enable`=1 for exactly one cycle and `new_record`=1 (held).
- DONE: `led`=0 and `cnt*` holds the final time.
- FOUL: `led`=0, `cnt*`=0000, `early`=1, no write.
- Simultaneous events:
  - `button` and `tick` in the same MEASURE cycle: `button` wins and `cnt*` is not incremented.
  - `button` and the final `tick` in WAIT: FOUL wins.
  - `start` and `button` in IDLE/DONE/FOUL: `start` is taken and `button` is ignored.
- Reset asserted mid-trial: immediate return to IDLE with all reset values; no partial write.

## Timing
- All outputs are registered. `led` and `busy` are decoded from the state register.
- `start` in cycle N → state WAIT, `busy`=1 in cycle N+1.
- Delay from WAIT entry to `led`=1 is exactly (WAIT_MIN_MS + rnd)·TICK_DIV cycles.
- MEASURE entry at cycle M: `cnt*`=0001 from cycle M+TICK_DIV onward. In general, `cnt*`=k after k·TICK_DIV cycles.
- `button` in cycle B (MEASURE) → DONE and `led`=0 in cycle B+1. `write_enable` is high only in B+1, and `cnt*` is stable from B onward.
- Reaction resolution is 1 ms, truncating (partial ms not counted).

## Test plan
Parameters for all scenarios: TICK_DIV=4, WAIT_MIN_MS=2, WAIT_RANGE_BITS=2; `rec*` comes from a memory model that resets to 9999.
- Reset then idle for 20 cycles → all outputs 0, state IDLE; `button` pulses produce no effect.
- `start`, then `button` 13 cycles after `led` rises → `cnt*`=0003, one-cycle `write_enable` the cycle after `button`, `new_record`=1, memory updates to 0003.
- Second trial with a reaction of 3 ms, then a third trial with 5 ms → `write_enable` stays 0 both times (tests equal and greater), `new_record`=0, record stays 0003.
- `button` during WAIT → FOUL; `early`=1, `led` never rises, no write; the next `start` clears `early`.
- Measure left running with `rec*` forced to 9999 → `cnt*` saturates at 9999 after 9999·4 cycles, DONE, no write. Also cover: `button` coincident with a `tick` at `cnt*`=0007 → final 0007.
- Reset asserted during MEASURE at `cnt*`=0002 → IDLE immediately, `cnt*`=0000, `led`=0, no `write_enable`. Also cover: `start` during MEASURE is ignored.
